// File: rtl/aes_pkg.sv
// Shared types and helpers for the AES masking front end: FSM state
// encoding for the mask refresher and the 32-bit Galois LFSR advance.
package aes_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GEN,
        START,
        WAIT,
        READY,
        ERR
    } mask_state_e;

    // Feedback polynomial x^32 + x^22 + x^2 + x + 1, right-shifting Galois form.
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    // Thirty-two single-bit Galois steps, unrolled. A nonzero state never maps
    // to zero because each step is invertible.
    function automatic logic [31:0] lfsr32_adv32(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        for (int i = 0; i < 32; i++) begin
            if (r[0]) begin
                r = (r >> 1) ^ LFSR_TAPS;
            end else begin
                r = r >> 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_lfsr32.sv
// Reseedable 32-bit Galois LFSR used as the mask PRNG. A load with a zero
// seed falls back to SEED so the register can never be stuck at zero.
module aes_lfsr32 import aes_pkg::*; #(
    parameter logic [31:0] SEED = 32'hA5C3_1E7B
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic [31:0] seed_i,
    input  logic        adv_i,
    output logic [31:0] next_o
);

    logic [31:0] state_q;
    logic [31:0] state_d;
    logic [31:0] adv_w;

    assign adv_w  = lfsr32_adv32(state_q);
    assign next_o = adv_w;

    // Next state: load takes priority over advance; they never coincide in use.
    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = (seed_i == 32'h0) ? SEED : seed_i;
        end else if (adv_i) begin
            state_d = adv_w;
        end
    end

    // State register, returns to SEED on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/aes_mask_refresh.sv
// Mask refresher ahead of the S-box precompute: draws 16 fresh combined-mask
// bytes, pulses the precompute start, waits for done under a timeout and
// hands the held masks to the round controller until it releases them.
module aes_mask_refresh import aes_pkg::*; #(
    parameter logic [31:0] SEED           = 32'hA5C3_1E7B,
    parameter int          TIMEOUT_CYCLES = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_i,
    input  logic         enc_dec_i,
    input  logic         reseed_i,
    input  logic [31:0]  seed_i,
    input  logic         release_i,
    output logic         busy_o,
    output logic         ready_o,
    output logic         err_o,
    output logic [127:0] mc_o,
    output logic         pc_start_o,
    output logic         pc_enc_dec_o,
    input  logic         pc_done_i
);

    // Last tmo_ctr value seen in WAIT before giving up; the increment that
    // reaches TIMEOUT_CYCLES-1 is the one that moves to ERR.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 2);

    mask_state_e  state_q, state_d;
    logic [127:0] mc_q, mc_d;
    logic         enc_q, enc_d;
    logic [1:0]   gen_ctr_q, gen_ctr_d;
    logic [15:0]  tmo_ctr_q, tmo_ctr_d;
    logic         lfsr_load;
    logic         lfsr_adv;
    logic [31:0]  lfsr_next;

    aes_lfsr32 #(
        .SEED (SEED)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .load_i (lfsr_load),
        .seed_i (seed_i),
        .adv_i  (lfsr_adv),
        .next_o (lfsr_next)
    );

    // Next-state, counter and mask-register update logic.
    always_comb begin
        state_d   = state_q;
        mc_d      = mc_q;
        enc_d     = enc_q;
        gen_ctr_d = gen_ctr_q;
        tmo_ctr_d = tmo_ctr_q;
        lfsr_load = 1'b0;
        lfsr_adv  = 1'b0;
        case (state_q)
            IDLE: begin
                // A same-cycle reseed lands before the first GEN advance.
                lfsr_load = reseed_i;
                if (req_i) begin
                    enc_d     = enc_dec_i;
                    gen_ctr_d = 2'd0;
                    state_d   = GEN;
                end
            end
            GEN: begin
                // Word k of the mask vector is the k-th freshly advanced state.
                lfsr_adv                       = 1'b1;
                mc_d[{gen_ctr_q, 5'd0} +: 32]  = lfsr_next;
                gen_ctr_d                      = gen_ctr_q + 2'd1;
                if (gen_ctr_q == 2'd3) begin
                    state_d = START;
                end
            end
            START: begin
                tmo_ctr_d = 16'd0;
                state_d   = WAIT;
            end
            WAIT: begin
                if (pc_done_i) begin
                    state_d = READY;
                end else begin
                    tmo_ctr_d = tmo_ctr_q + 16'd1;
                    if (tmo_ctr_q == TMO_LAST) begin
                        state_d = ERR;
                        mc_d    = '0;
                    end
                end
            end
            READY: begin
                if (release_i) begin
                    state_d = IDLE;
                    mc_d    = '0;
                end
            end
            ERR: begin
                if (release_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                mc_d    = '0;
            end
        endcase
    end

    // State, counters and held masks; reset aborts any operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            mc_q      <= '0;
            enc_q     <= 1'b0;
            gen_ctr_q <= 2'd0;
            tmo_ctr_q <= 16'd0;
        end else begin
            state_q   <= state_d;
            mc_q      <= mc_d;
            enc_q     <= enc_d;
            gen_ctr_q <= gen_ctr_d;
            tmo_ctr_q <= tmo_ctr_d;
        end
    end

    // Outputs decode registered state only.
    assign busy_o       = (state_q == GEN) || (state_q == START) || (state_q == WAIT);
    assign ready_o      = (state_q == READY);
    assign err_o        = (state_q == ERR);
    assign pc_start_o   = (state_q == START);
    assign mc_o         = mc_q;
    assign pc_enc_dec_o = enc_q;

endmodule
